// File: rtl/core_dispatch_scheduler.sv
// core_dispatch_scheduler: runs one 16x16 tile at a time through the CNN or
// SNN core. It latches the allocator's route, waits for the tile, emits the
// core start pulse and the per-pixel stream enable, then collects and holds
// the selected core's result until the consumer accepts it.
// Optional feature macro: SCHED_STATS_EN (per-path completed-tile counters).
module core_dispatch_scheduler #(
    parameter int TILE_PIXELS    = 256,
    parameter int START_DELAY    = 2,
    parameter int RESULT_W       = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iDecisionValid,
    input  logic                iRouteToCnn,
    input  logic                iTileReady,
    output logic                oCoreStart,
    output logic                oCnnValid,
    output logic                oSnnValid,
    input  logic                iCnnResValid,
    input  logic [RESULT_W-1:0] iCnnResult,
    input  logic                iSnnResValid,
    input  logic [RESULT_W-1:0] iSnnResult,
    output logic [RESULT_W-1:0] oResult,
    output logic                oResultValid,
    input  logic                iResultReady,
    output logic                oResultIsCnn,
    output logic                oBusy,
    output logic                oOverflow,
    output logic                oTimeout,
    output logic [15:0]         oCnnCount,
    output logic [15:0]         oSnnCount
);

    localparam int PIX_W = $clog2(TILE_PIXELS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TILE = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_WAIT_RES  = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;

    logic [2:0]          state_q, state_d;
    logic                route_q, route_d;
    logic                pend_vld_q, pend_vld_d;
    logic                pend_route_q, pend_route_d;
    logic                tile_q, tile_d;
    logic [3:0]          dly_q, dly_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [TO_W-1:0]     wait_q, wait_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                res_cnn_q, res_cnn_d;
    logic                res_vld_q, res_vld_d;
    logic                ovf_q, ovf_d;
    logic                to_q, to_d;
    logic                tile_hit;
    logic                tile_leave;
    logic                pend_take;
    logic                res_hit;

    assign tile_hit = tile_q | iTileReady;
    assign res_hit  = route_q ? iCnnResValid : iSnnResValid;

    // Next-state logic for the tile sequencer, pending slot and result holder.
    always_comb begin
        state_d      = state_q;
        route_d      = route_q;
        pend_vld_d   = pend_vld_q;
        pend_route_d = pend_route_q;
        dly_d        = dly_q;
        pix_d        = pix_q;
        wait_d       = wait_q;
        result_d     = result_q;
        res_cnn_d    = res_cnn_q;
        res_vld_d    = res_vld_q;
        ovf_d        = 1'b0;
        to_d         = 1'b0;
        tile_leave   = 1'b0;
        pend_take    = 1'b0;

        case (state_q)
            S_IDLE: begin
                dly_d = 4'd0;
                if (iDecisionValid) begin
                    route_d = iRouteToCnn;
                    // A tile that is already waiting lets the decision pass
                    // straight through WAIT_TILE, so start follows next cycle.
                    if (tile_hit) begin
                        state_d    = S_START;
                        tile_leave = 1'b1;
                    end else begin
                        state_d = S_WAIT_TILE;
                    end
                end
            end
            S_WAIT_TILE: begin
                dly_d = 4'd0;
                if (tile_hit) begin
                    state_d    = S_START;
                    tile_leave = 1'b1;
                end
            end
            S_START: begin
                if (dly_q == 4'(START_DELAY - 1)) begin
                    state_d = S_STREAM;
                    pix_d   = '0;
                end else begin
                    dly_d = dly_q + 4'd1;
                end
            end
            S_STREAM: begin
                if (pix_q == PIX_W'(TILE_PIXELS - 1)) begin
                    state_d = S_WAIT_RES;
                    wait_d  = '0;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            S_WAIT_RES: begin
                if (res_hit) begin
                    result_d  = route_q ? iCnnResult : iSnnResult;
                    res_cnn_d = route_q;
                    res_vld_d = 1'b1;
                    state_d   = S_HOLD;
                end else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_d      = 1'b1;
                    pend_take = pend_vld_q;
                    state_d   = pend_vld_q ? S_WAIT_TILE : S_IDLE;
                    if (pend_vld_q) route_d = pend_route_q;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (iResultReady) begin
                    res_vld_d = 1'b0;
                    pend_take = pend_vld_q;
                    state_d   = pend_vld_q ? S_WAIT_TILE : S_IDLE;
                    if (pend_vld_q) route_d = pend_route_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One-deep pending slot; a slot being drained this cycle can take
        // the new decision so nothing arriving on the HOLD exit is lost.
        if (pend_take) pend_vld_d = 1'b0;
        if (iDecisionValid && (state_q != S_IDLE)) begin
            if (!pend_vld_q || pend_take) begin
                pend_vld_d   = 1'b1;
                pend_route_d = iRouteToCnn;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Tile flag remembers a ready pulse until WAIT_TILE is left.
    assign tile_d = tile_leave ? 1'b0 : tile_hit;

    // State and datapath registers.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q      <= S_IDLE;
            route_q      <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_route_q <= 1'b0;
            tile_q       <= 1'b0;
            dly_q        <= 4'd0;
            pix_q        <= '0;
            wait_q       <= '0;
            result_q     <= '0;
            res_cnn_q    <= 1'b0;
            res_vld_q    <= 1'b0;
            ovf_q        <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            route_q      <= route_d;
            pend_vld_q   <= pend_vld_d;
            pend_route_q <= pend_route_d;
            tile_q       <= tile_d;
            dly_q        <= dly_d;
            pix_q        <= pix_d;
            wait_q       <= wait_d;
            result_q     <= result_d;
            res_cnn_q    <= res_cnn_d;
            res_vld_q    <= res_vld_d;
            ovf_q        <= ovf_d;
            to_q         <= to_d;
        end
    end

    assign oCoreStart   = (state_q == S_START) && (dly_q == 4'd0);
    assign oCnnValid    = (state_q == S_STREAM) && route_q;
    assign oSnnValid    = (state_q == S_STREAM) && !route_q;
    assign oResult      = result_q;
    assign oResultValid = res_vld_q;
    assign oResultIsCnn = res_cnn_q;
    assign oBusy        = (state_q != S_IDLE);
    assign oOverflow    = ovf_q;
    assign oTimeout     = to_q;

`ifdef SCHED_STATS_EN
    logic        accept;
    logic [15:0] cnn_cnt_q, snn_cnt_q;

    assign accept = (state_q == S_HOLD) && iResultReady;

    // Saturating per-path counters of accepted results.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnn_cnt_q <= 16'd0;
            snn_cnt_q <= 16'd0;
        end else if (accept) begin
            if (res_cnn_q && (cnn_cnt_q != 16'hFFFF)) cnn_cnt_q <= cnn_cnt_q + 16'd1;
            if (!res_cnn_q && (snn_cnt_q != 16'hFFFF)) snn_cnt_q <= snn_cnt_q + 16'd1;
        end
    end

    assign oCnnCount = cnn_cnt_q;
    assign oSnnCount = snn_cnt_q;
`else
    assign oCnnCount = 16'd0;
    assign oSnnCount = 16'd0;
`endif

endmodule

// File: tb/tb_core_dispatch_scheduler.sv
// Directed bench for core_dispatch_scheduler: routing, tile-flag retention,
// start/stream timing, result hold, pending/overflow, timeout and async reset.
module tb_core_dispatch_scheduler;

    localparam int TP = 256;
    localparam int TO = 4096;
`ifdef SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_vld, route_cnn, tile_rdy;
    logic        core_start, cnn_vld, snn_vld;
    logic        cnn_res_vld, snn_res_vld;
    logic [7:0]  cnn_res, snn_res;
    logic [7:0]  result;
    logic        res_vld, res_rdy, res_is_cnn;
    logic        busy, ovf, tmo;
    logic [15:0] cnn_cnt, snn_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int hc, hs, seen;

    core_dispatch_scheduler dut (
        .iClk(clk), .iRst(rst_n),
        .iDecisionValid(dec_vld), .iRouteToCnn(route_cnn), .iTileReady(tile_rdy),
        .oCoreStart(core_start), .oCnnValid(cnn_vld), .oSnnValid(snn_vld),
        .iCnnResValid(cnn_res_vld), .iCnnResult(cnn_res),
        .iSnnResValid(snn_res_vld), .iSnnResult(snn_res),
        .oResult(result), .oResultValid(res_vld), .iResultReady(res_rdy),
        .oResultIsCnn(res_is_cnn), .oBusy(busy), .oOverflow(ovf), .oTimeout(tmo),
        .oCnnCount(cnn_cnt), .oSnnCount(snn_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count stream-enable cycles over a window of TP cycles.
    task automatic count_stream();
        hc = 0;
        hs = 0;
        for (int i = 0; i < TP; i++) begin
            if (cnn_vld) hc++;
            if (snn_vld) hs++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; dec_vld = 0; route_cnn = 0; tile_rdy = 0;
        cnn_res_vld = 0; snn_res_vld = 0; cnn_res = 0; snn_res = 0; res_rdy = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", core_start, 0);
        chk("rst_valid", {cnn_vld, snn_vld}, 0);
        chk("rst_resvld", res_vld, 0);
        chk("rst_counts", {cnn_cnt, snn_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // CNN decision, tile 10 cycles later: start next cycle, stream after 2.
        dec_vld = 1; route_cnn = 1; tick(); dec_vld = 0;
        chk("t1_busy", busy, 1);
        chk("t1_nostart", core_start, 0);
        repeat (9) tick();
        tile_rdy = 1; tick(); tile_rdy = 0;
        chk("t1_start", core_start, 1);
        chk("t1_novalid_s", cnn_vld, 0);
        tick();
        chk("t1_start_once", core_start, 0);
        chk("t1_novalid_d", cnn_vld, 0);
        tick();
        count_stream();
        chk("t1_cnn_len", hc, TP);
        chk("t1_snn_len", hs, 0);
        chk("t1_stream_end", cnn_vld, 0);

        // Foreign strobe ignored, own strobe latched with 1-cycle latency.
        snn_res_vld = 1; snn_res = 8'hAA; tick(); snn_res_vld = 0;
        chk("t3_ignore_snn", res_vld, 0);
        chk("t3_busy", busy, 1);
        cnn_res_vld = 1; cnn_res = 8'h3C; tick(); cnn_res_vld = 0; cnn_res = 8'h00;
        chk("t3_resvld", res_vld, 1);
        chk("t3_result", result, 8'h3C);
        chk("t3_is_cnn", res_is_cnn, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_vld !== 1'b1 || result !== 8'h3C || res_is_cnn !== 1'b1) seen++;
        end
        chk("t3_hold_stable", seen, 0);
        res_rdy = 1; tick(); res_rdy = 0;
        chk("t3_cleared", res_vld, 0);
        chk("t3_idle", busy, 0);
        chk("t3_cnn_cnt", cnn_cnt, STATS * 1);

        // Tile pulse long before the SNN decision is retained.
        tile_rdy = 1; tick(); tile_rdy = 0;
        repeat (24) tick();
        chk("t2_idle_wait", busy, 0);
        chk("t2_nostart", core_start, 0);
        dec_vld = 1; route_cnn = 0; tick(); dec_vld = 0;
        chk("t2_start", core_start, 1);
        tick(); tick();
        count_stream();
        chk("t2_snn_len", hs, TP);
        chk("t2_cnn_len", hc, 0);
        snn_res_vld = 1; snn_res = 8'h5A; tick(); snn_res_vld = 0;
        chk("t2_result", result, 8'h5A);
        chk("t2_is_cnn", res_is_cnn, 0);
        res_rdy = 1; tick(); res_rdy = 0;
        chk("t2_snn_cnt", snn_cnt, STATS * 1);
        chk("t2_cnn_cnt", cnn_cnt, STATS * 1);

        // Three decisions while busy: second pends, third overflows.
        dec_vld = 1; route_cnn = 1; tick();
        route_cnn = 0; tick();
        chk("t4_no_ovf", ovf, 0);
        route_cnn = 1; tick(); dec_vld = 0;
        chk("t4_ovf", ovf, 1);
        tick();
        chk("t4_ovf_pulse", ovf, 0);
        tile_rdy = 1; tick(); tile_rdy = 0;
        chk("t4_start", core_start, 1);
        tick(); tick();
        count_stream();
        chk("t4_cnn_len", hc, TP);
        cnn_res_vld = 1; cnn_res = 8'h11; tick(); cnn_res_vld = 0;
        chk("t4_result", result, 8'h11);
        res_rdy = 1; tick(); res_rdy = 0;
        chk("t4_pend_busy", busy, 1);
        chk("t4_pend_nostart", core_start, 0);
        chk("t4_cnn_cnt", cnn_cnt, STATS * 2);
        tile_rdy = 1; tick(); tile_rdy = 0;
        chk("t4_pend_start", core_start, 1);
        tick(); tick();
        chk("t4_pend_snn", {cnn_vld, snn_vld}, 2'b01);
        tick();
        repeat (TP - 1) tick();

        // No strobe: timeout after TO cycles in WAIT_RESULT.
        repeat (TO - 1) tick();
        chk("t5_pre_tmo", tmo, 0);
        chk("t5_pre_busy", busy, 1);
        tick();
        chk("t5_tmo", tmo, 1);
        chk("t5_busy", busy, 0);
        chk("t5_noresult", res_vld, 0);
        tick();
        chk("t5_tmo_pulse", tmo, 0);
        chk("t5_counts", {cnn_cnt, snn_cnt}, {16'(STATS * 2), 16'(STATS * 1)});

        // Asynchronous reset during stream cycle 100.
        dec_vld = 1; route_cnn = 1; tile_rdy = 1; tick(); dec_vld = 0; tile_rdy = 0;
        tick(); tick();
        repeat (100) tick();
        chk("t6_streaming", cnn_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {cnn_vld, snn_vld, core_start}, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_counts", {cnn_cnt, snn_cnt}, 0);
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_start || cnn_vld || snn_vld || busy) seen++;
        end
        chk("t6_quiet", seen, 0);
        tile_rdy = 1; tick(); tile_rdy = 0;
        tick();
        chk("t6_tile_only", {core_start, busy}, 0);
        dec_vld = 1; route_cnn = 0; tick(); dec_vld = 0;
        chk("t6_restart", core_start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
